// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 keyboard receiver: frame FSM encoding,
// scan-code constants and the mapping from codes to game keys.
package ps2_pkg;

  localparam int TIMEOUT_CYC_DEF = 100000;
  localparam int FILT_LEN_DEF    = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_e;

  localparam logic [7:0] SC_EXT       = 8'hE0;
  localparam logic [7:0] SC_BRK       = 8'hF0;
  localparam logic [7:0] SC_LEFT_EXT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT_EXT = 8'h74;
  localparam logic [7:0] SC_JUMP_EXT  = 8'h75;
  localparam logic [7:0] SC_LEFT      = 8'h1C;
  localparam logic [7:0] SC_RIGHT     = 8'h23;
  localparam logic [7:0] SC_JUMP      = 8'h29;
  localparam logic [7:0] SC_START     = 8'h5A;

  typedef enum logic [2:0] {
    KEY_NONE,
    KEY_LEFT,
    KEY_RIGHT,
    KEY_JUMP,
    KEY_START
  } key_id_e;

  // Extended codes (after E0) and plain codes live in separate tables.
  function automatic key_id_e map_key(input logic ext, input logic [7:0] code);
    key_id_e id;
    id = KEY_NONE;
    if (ext) begin
      case (code)
        SC_LEFT_EXT:  id = KEY_LEFT;
        SC_RIGHT_EXT: id = KEY_RIGHT;
        SC_JUMP_EXT:  id = KEY_JUMP;
        default:      id = KEY_NONE;
      endcase
    end else begin
      case (code)
        SC_LEFT:  id = KEY_LEFT;
        SC_RIGHT: id = KEY_RIGHT;
        SC_JUMP:  id = KEY_JUMP;
        SC_START: id = KEY_START;
        default:  id = KEY_NONE;
      endcase
    end
    return id;
  endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 frame receiver: synchronises the keyboard lines, deglitches the clock,
// and assembles 11-bit frames into bytes with parity/stop/timeout checking.
module ps2_rx_frame
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  parameter int FILT_LEN    = FILT_LEN_DEF
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       byte_err
);

  localparam int FCW = $clog2(FILT_LEN + 1);
  localparam int TCW = $clog2(TIMEOUT_CYC + 1);

  logic [1:0]     clk_sync;
  logic [1:0]     data_sync;
  logic [FCW-1:0] filt_cnt;
  logic           filt_clk;
  logic           filt_prev;
  logic           strobe;
  logic           bit_in;

  rx_state_e      state;
  logic [7:0]     shift;
  logic [2:0]     bit_cnt;
  logic           par_ok;
  logic [TCW-1:0] tmo_cnt;
  logic           tmo_hit;
  logic           stop_strobe;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
    end
  end

  // The filtered level only follows after FILT_LEN consecutive disagreeing samples.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      filt_cnt  <= '0;
      filt_clk  <= 1'b1;
      filt_prev <= 1'b1;
    end else begin
      filt_prev <= filt_clk;
      if (clk_sync[1] == filt_clk) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FCW'(FILT_LEN - 1)) begin
        filt_clk <= clk_sync[1];
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + 1'b1;
      end
    end
  end

  assign strobe      = filt_prev & ~filt_clk;
  assign bit_in      = data_sync[1];
  assign tmo_hit     = (state != ST_IDLE) && !strobe && (tmo_cnt == TCW'(TIMEOUT_CYC - 1));
  assign stop_strobe = strobe && (state == ST_STOP);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state   <= ST_IDLE;
      shift   <= '0;
      bit_cnt <= '0;
      par_ok  <= 1'b0;
      tmo_cnt <= '0;
    end else begin
      if (state == ST_IDLE || strobe) begin
        tmo_cnt <= '0;
      end else begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end

      if (tmo_hit) begin
        state   <= ST_IDLE;
        bit_cnt <= '0;
      end else if (strobe) begin
        case (state)
          ST_IDLE: begin
            if (!bit_in) begin
              state   <= ST_DATA;
              bit_cnt <= '0;
            end
          end
          ST_DATA: begin
            shift   <= {bit_in, shift[7:1]};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) begin
              state <= ST_PARITY;
            end
          end
          ST_PARITY: begin
            par_ok <= ^{shift, bit_in};
            state  <= ST_STOP;
          end
          ST_STOP: begin
            state <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  // Events are flagged in the stop-strobe cycle; the decoder registers them.
  assign byte_data  = shift;
  assign byte_valid = stop_strobe && bit_in && par_ok;
  assign byte_err   = (stop_strobe && !(bit_in && par_ok)) || tmo_hit;

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard decoder: turns received bytes into scan codes and held-key
// levels for left/right/jump plus a start pulse on the first Enter press.
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  parameter int FILT_LEN    = FILT_LEN_DEF
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] scan_code,
  output logic       scan_valid,
  output logic       frame_err,
  output logic       key_left,
  output logic       key_right,
  output logic       key_jump,
  output logic       key_start
);

  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       rx_err;
  logic       ext;
  logic       brk;
  logic       start_held;
  key_id_e    key_id;

  ps2_rx_frame #(
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .FILT_LEN    (FILT_LEN)
  ) u_rx (
    .clk        (clk),
    .rstn       (rstn),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .byte_data  (rx_byte),
    .byte_valid (rx_valid),
    .byte_err   (rx_err)
  );

  assign key_id = map_key(ext, rx_byte);

  // Prefix bytes only arm ext/brk; the next real code consumes and clears them.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      scan_code  <= '0;
      scan_valid <= 1'b0;
      frame_err  <= 1'b0;
      key_left   <= 1'b0;
      key_right  <= 1'b0;
      key_jump   <= 1'b0;
      key_start  <= 1'b0;
      start_held <= 1'b0;
      ext        <= 1'b0;
      brk        <= 1'b0;
    end else begin
      scan_valid <= rx_valid;
      frame_err  <= rx_err;
      key_start  <= 1'b0;
      if (rx_err) begin
        ext <= 1'b0;
        brk <= 1'b0;
      end else if (rx_valid) begin
        if (rx_byte == SC_EXT) begin
          ext <= 1'b1;
        end else if (rx_byte == SC_BRK) begin
          brk <= 1'b1;
        end else begin
          scan_code <= rx_byte;
          ext       <= 1'b0;
          brk       <= 1'b0;
          case (key_id)
            KEY_LEFT:  key_left  <= !brk;
            KEY_RIGHT: key_right <= !brk;
            KEY_JUMP:  key_jump  <= !brk;
            KEY_START: begin
              start_held <= !brk;
              key_start  <= !brk && !start_held;
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench: frames are bit-banged onto the PS/2 lines and each expected
// decoder response is queued for a monitor that checks every output event.
module tb_ps2_key_decoder;

  typedef struct {
    logic       is_err;
    logic [7:0] code;
    logic       l;
    logic       r;
    logic       j;
    logic       s;
  } exp_t;

  logic       clk = 1'b0;
  logic       rstn;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] scan_code;
  logic       scan_valid;
  logic       frame_err;
  logic       key_left;
  logic       key_right;
  logic       key_jump;
  logic       key_start;

  exp_t exp_q[$];
  exp_t mon_e;
  int   assert_cnt = 0;
  int   fail_cnt   = 0;
  int   cyc        = 0;
  int   last_fall  = 0;
  int   lat;

  ps2_key_decoder #(
    .TIMEOUT_CYC (1000),
    .FILT_LEN    (8)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .scan_code  (scan_code),
    .scan_valid (scan_valid),
    .frame_err  (frame_err),
    .key_left   (key_left),
    .key_right  (key_right),
    .key_jump   (key_jump),
    .key_start  (key_start)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    assert_cnt++;
    if (actual !== expected) begin
      fail_cnt++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic sendFrame(input logic [7:0] d, input logic bad_par, input int nbits);
    logic [10:0] fr;
    fr = {1'b1, (~^d) ^ bad_par, d, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = fr[i];
      waitCycles(15);
      ps2_clk   = 1'b0;
      last_fall = cyc;
      waitCycles(30);
      ps2_clk = 1'b1;
      waitCycles(15);
    end
    ps2_data = 1'b1;
    waitCycles(40);
  endtask

  task automatic applyStimulus(input logic [7:0] d, input logic bad_par, input logic is_err,
                               input logic [7:0] code, input logic l, input logic r,
                               input logic j, input logic s);
    exp_t e;
    e.is_err = is_err;
    e.code   = code;
    e.l      = l;
    e.r      = r;
    e.j      = j;
    e.s      = s;
    exp_q.push_back(e);
    sendFrame(d, bad_par, 11);
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_scan_code"},  {24'd0, scan_code}, 32'h00);
    checkOutput({tag, "_scan_valid"}, {31'd0, scan_valid}, 32'd0);
    checkOutput({tag, "_frame_err"},  {31'd0, frame_err}, 32'd0);
    checkOutput({tag, "_key_left"},   {31'd0, key_left}, 32'd0);
    checkOutput({tag, "_key_right"},  {31'd0, key_right}, 32'd0);
    checkOutput({tag, "_key_jump"},   {31'd0, key_jump}, 32'd0);
    checkOutput({tag, "_key_start"},  {31'd0, key_start}, 32'd0);
  endtask

  // Monitor: every scan_valid/frame_err cycle consumes one queued expectation.
  always @(negedge clk) begin
    if (rstn === 1'b1) begin
      if (scan_valid || frame_err) begin
        checkOutput("expect_available", {31'd0, exp_q.size() != 0}, 32'd1);
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          checkOutput("scan_valid", {31'd0, scan_valid}, {31'd0, !mon_e.is_err});
          checkOutput("frame_err",  {31'd0, frame_err},  {31'd0, mon_e.is_err});
          checkOutput("scan_code",  {24'd0, scan_code},  {24'd0, mon_e.code});
          checkOutput("key_left",   {31'd0, key_left},   {31'd0, mon_e.l});
          checkOutput("key_right",  {31'd0, key_right},  {31'd0, mon_e.r});
          checkOutput("key_jump",   {31'd0, key_jump},   {31'd0, mon_e.j});
          checkOutput("key_start",  {31'd0, key_start},  {31'd0, mon_e.s});
        end
      end else if (key_start) begin
        checkOutput("key_start_with_valid", {31'd0, scan_valid}, 32'd1);
      end
    end
  end

  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: simulation time limit reached, queue depth %0d, required 0", exp_q.size());
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rstn     = 1'b0;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    waitCycles(5);
    checkIdleOutputs("reset");
    rstn = 1'b1;
    waitCycles(20);

    // d, bad_par, is_err, code, left, right, jump, start
    applyStimulus(8'h1C, 0, 0, 8'h1C, 1, 0, 0, 0);
    applyStimulus(8'hF0, 0, 0, 8'h1C, 1, 0, 0, 0);
    applyStimulus(8'h1C, 0, 0, 8'h1C, 0, 0, 0, 0);
    applyStimulus(8'hE0, 0, 0, 8'h1C, 0, 0, 0, 0);
    applyStimulus(8'h6B, 0, 0, 8'h6B, 1, 0, 0, 0);
    applyStimulus(8'hE0, 0, 0, 8'h6B, 1, 0, 0, 0);
    applyStimulus(8'hF0, 0, 0, 8'h6B, 1, 0, 0, 0);
    applyStimulus(8'h6B, 0, 0, 8'h6B, 0, 0, 0, 0);
    applyStimulus(8'hE0, 0, 0, 8'h6B, 0, 0, 0, 0);
    applyStimulus(8'h6B, 0, 0, 8'h6B, 1, 0, 0, 0);
    applyStimulus(8'hE0, 0, 0, 8'h6B, 1, 0, 0, 0);
    applyStimulus(8'h74, 0, 0, 8'h74, 1, 1, 0, 0);
    applyStimulus(8'h29, 1, 1, 8'h74, 1, 1, 0, 0);
    applyStimulus(8'hE0, 0, 0, 8'h74, 1, 1, 0, 0);
    applyStimulus(8'hF0, 0, 0, 8'h74, 1, 1, 0, 0);
    applyStimulus(8'h74, 0, 0, 8'h74, 1, 0, 0, 0);

    // Start bit plus three data bits, then silence until the receiver times out.
    begin
      exp_t e;
      e.is_err = 1; e.code = 8'h74; e.l = 1; e.r = 0; e.j = 0; e.s = 0;
      exp_q.push_back(e);
    end
    sendFrame(8'hF0, 0, 4);
    while (!frame_err && (cyc - last_fall) < 1500) waitCycles(1);
    lat = cyc - last_fall;
    assert_cnt++;
    if (lat < 1006 || lat > 1016) begin
      fail_cnt++;
      $display("[TB] FAIL timeout_latency: got %0d cycles after last clock fall, required 1006..1016", lat);
    end
    waitCycles(20);

    applyStimulus(8'h23, 0, 0, 8'h23, 1, 1, 0, 0);
    applyStimulus(8'h5A, 0, 0, 8'h5A, 1, 1, 0, 1);
    applyStimulus(8'h5A, 0, 0, 8'h5A, 1, 1, 0, 0);
    applyStimulus(8'h5A, 0, 0, 8'h5A, 1, 1, 0, 0);
    applyStimulus(8'hF0, 0, 0, 8'h5A, 1, 1, 0, 0);
    applyStimulus(8'h5A, 0, 0, 8'h5A, 1, 1, 0, 0);
    applyStimulus(8'h5A, 0, 0, 8'h5A, 1, 1, 0, 1);
    applyStimulus(8'hE0, 0, 0, 8'h5A, 1, 1, 0, 0);

    // Reset in the middle of an E0 frame with ext already armed.
    sendFrame(8'hE0, 0, 6);
    rstn = 1'b0;
    waitCycles(1);
    checkIdleOutputs("midframe_reset");
    rstn = 1'b1;
    waitCycles(20);

    applyStimulus(8'h75, 0, 0, 8'h75, 0, 0, 0, 0);
    applyStimulus(8'hE0, 0, 0, 8'h75, 0, 0, 0, 0);
    applyStimulus(8'h75, 0, 0, 8'h75, 0, 0, 1, 0);
    applyStimulus(8'h29, 0, 0, 8'h29, 0, 0, 1, 0);
    applyStimulus(8'hF0, 0, 0, 8'h29, 0, 0, 1, 0);
    applyStimulus(8'h29, 0, 0, 8'h29, 0, 0, 0, 0);

    for (int i = 0; i < 2000 && exp_q.size() != 0; i++) waitCycles(1);
    checkOutput("queue_drained", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule
